// File: rtl/onehot_seq_monitor.sv
// Tracks a walking one-hot LED vector, locks after LOCK_N in-order samples, counts lock losses and laps.
// Optional lap counter built only when ONEHOT_MON_LAP_EN is defined; otherwise lap_count reads 0.
module onehot_seq_monitor #(
    parameter int LOCK_N = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [15:0] pattern,
    input  logic        clr_cnt,
    output logic [3:0]  index,
    output logic        onehot_ok,
    output logic        locked,
    output logic        seq_error,
    output logic [7:0]  err_count,
    output logic [7:0]  lap_count
);

    // Out-of-range lock thresholds fall back to the longest legal run.
    localparam logic [3:0] LOCK_EFF = (LOCK_N < 1 || LOCK_N > 15) ? 4'd15 : LOCK_N[3:0];

    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [3:0]  last_q, last_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  index_q, index_d;
    logic        onehot_ok_q, onehot_ok_d;
    logic        seq_error_q, seq_error_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        err_inc;

    logic        valid;
    logic        succ;
    logic [3:0]  enc;

    assign valid = (pattern != 16'h0000) && ((pattern & (pattern - 16'd1)) == 16'h0000);
    assign succ  = valid && (enc == last_q + 4'd1);

    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern[i]) enc = 4'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        good_d      = good_q;
        index_d     = index_q;
        onehot_ok_d = onehot_ok_q;
        seq_error_d = 1'b0;
        err_inc     = 1'b0;
        if (sample_en) begin
            onehot_ok_d = valid;
            if (valid) index_d = enc;
            case (state_q)
                HUNT: begin
                    if (valid) begin
                        last_d  = enc;
                        good_d  = 4'd1;
                        state_d = (LOCK_EFF == 4'd1) ? LOCKED : ACQ;
                    end
                end
                ACQ: begin
                    if (!valid) begin
                        state_d = HUNT;
                    end else if (succ) begin
                        last_d = enc;
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_EFF) state_d = LOCKED;
                    end else begin
                        last_d = enc;
                        good_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (succ) begin
                        last_d = enc;
                    end else begin
                        seq_error_d = 1'b1;
                        err_inc     = 1'b1;
                        state_d     = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        // Clear wins over a same-cycle increment; the error pulse still fires.
        if (clr_cnt)
            err_count_d = 8'd0;
        else if (err_inc && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
        else
            err_count_d = err_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            last_q      <= 4'd0;
            good_q      <= 4'd0;
            index_q     <= 4'd0;
            onehot_ok_q <= 1'b0;
            seq_error_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            good_q      <= good_d;
            index_q     <= index_d;
            onehot_ok_q <= onehot_ok_d;
            seq_error_q <= seq_error_d;
            err_count_q <= err_count_d;
        end
    end

`ifdef ONEHOT_MON_LAP_EN
    logic [7:0] lap_count_q;
    logic       lap_wrap;

    assign lap_wrap = sample_en && (state_q == LOCKED) && succ && (last_q == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         lap_count_q <= 8'd0;
        else if (clr_cnt)  lap_count_q <= 8'd0;
        else if (lap_wrap) lap_count_q <= lap_count_q + 8'd1;
    end

    assign lap_count = lap_count_q;
`else
    assign lap_count = 8'h00;
`endif

    assign index     = index_q;
    assign onehot_ok = onehot_ok_q;
    assign locked    = (state_q == LOCKED);
    assign seq_error = seq_error_q;
    assign err_count = err_count_q;

endmodule
